chan_out_bank: RTL and testbench
================================

# chan_out_bank

Parametrised bank of N AGC output channels, the next-generation successor to the fixed four-channel output-register modules (channels 05/06/11/12 style). Each channel is a W-bit register written from the active-low channel write lines with load, OR (WOR) or AND (WAND) semantics. Channels can be cleared and read back onto the active-low CHOR_ bus. Two further features are new to this block: per-bit DSKY-style flash gating, and a minimum-on-time stretcher for RCS jet-command bits.

## Interface
- N, 4, number of channels in the bank (1–8)
- W, 14, channel width in bits (1–16)
- BASE_CH, 5, channel address of channel 0; channel k answers at BASE_CH+k
- FLASH_MASK, 0, N*W bits; a set bit makes that output bit flash-gated
- JET_MASK, 0, N*W bits; a set bit makes that output bit subject to the minimum on-time
- MINON, 8, minimum on-time in CLOCK cycles (≥1)

- CLOCK  in  1  sole clock; rising edge
- rst_  in  1  asynchronous, active-low reset
- GOJAM  in  1  synchronous clear of all channels and timers
- CHAN  in  9  channel address
- WCH_  in  1  active-low write strobe
- WMODE  in  2  write mode: 00 load, 01 OR, 10 AND, 11 treated as load
- CCH_  in  1  active-low clear strobe
- RCH_  in  1  active-low read strobe
- CHWL_  in  W  active-low write data
- FLASH  in  1  flash phase; 1 = lit
- CHOR_  out  W  active-low read bus
- CHAN_Q  out  N*W  effective channel outputs; channel k occupies bits [k*W +: W]

## Operation
- Hit: k = CHAN−BASE_CH, and only when 0 ≤ k < N. A miss ignores all strobes.
- Write data: D = ~CHWL_.
- Per-cycle update for a hit channel k, in priority order:
  - GOJAM: every channel register and timer goes to 0, regardless of address.
  - Otherwise, with CCH_=0, the base value is 0; else it is the current register R.
  - With WCH_=0, the new R is computed from the base: load → D; OR → base|D; AND → base&D.
- CCH_ and WCH_ asserted together: the clear is applied first, then the write. Results: load gives D, OR gives D, AND gives 0.
- Read: with RCH_=0 on a hit, the CHOR_ register is loaded with ~R_k as it stood before the same edge's update. Otherwise CHOR_ is loaded with all ones.
- Jet stretcher: applies to bits with JET_MASK=1 and uses a per-bit down-counter T of width $clog2(MINON+1).
  - When R's bit goes 0→1, T loads MINON−1.
  - While T>0, T decrements every cycle.
  - The hold term is H = (T>0).
  - Effective bit E = R | H.
  - A 1→0→1 transition of R reloads T.
- Bits with JET_MASK=0 have H=0.
- Flash gating: CHAN_Q bit = E & (FLASH | ~FLASH_MASK).

## Timing
- Reset (rst_=0, async): all R=0, all T=0, CHAN_Q=0, CHOR_ all ones.
- R updates on the CLOCK edge on which the strobe is sampled low. CHAN_Q is registered and reflects the new R one edge later (latency 2 edges from the strobe).
- CHOR_ is valid the edge after RCH_ is sampled low and holds for exactly one cycle unless RCH_ stays low.
- FLASH is sampled into CHAN_Q with the same single-register latency.
- Jet minimum on-time: a jet bit set for a single cycle appears high on CHAN_Q for exactly MINON cycles.
- A jet bit held in R longer than MINON cycles appears for its R duration.
- GOJAM kills stretching immediately: CHAN_Q is 0 one edge after GOJAM is sampled.
- Reset released mid-stretch: timers restart from 0; there is no residual hold.
- No handshake: strobes are level-sampled every cycle, and back-to-back writes to the same channel are legal.

## Structure
- Shared package chan_pkg:
  - WMODE encodings (WM_LOAD, WM_OR, WM_AND)
  - channel-address width (9)
  - the hit-decode function
- Sub-module jet_stretch: one bit plus its counter, parameter MINON. Instantiate it in a generate loop only where JET_MASK is set.
- Everything else is in the top module.

## Test plan
- Reset, then defaults (BASE_CH=5, N=4, W=14): write load CHAN=6, CHWL_=~14'h0155. After 2 edges CHAN_Q[27:14]=14'h0155; all other channels are 0.
- OR then AND on channel 5: load 14'h00F0, OR 14'h000F, AND 14'h003C. R = 14'h00FF, then 14'h003C. Read on CHAN=5 gives CHOR_=~14'h003C the next cycle.
- Simultaneous CCH_ and WCH_ (load, D=14'h1234): R=14'h1234. Repeating with AND mode gives R=0. A write to CHAN=9 or CHAN=4 leaves all channels unchanged.
- JET_MASK bit 0 set, MINON=8: set bit 0 for 1 cycle, then clear it. CHAN_Q[0] is high for exactly 8 cycles. Re-setting at cycle 5 extends the hold to 8 cycles from the re-set.
- FLASH_MASK bit 3 set, R bit 3 = 1: toggle FLASH 1/0/1. CHAN_Q[3] follows FLASH with 1-edge lag. Unmasked bits stay 1.
- GOJAM mid-stretch with channels loaded: CHAN_Q = 0 one edge later. Asserting rst_ low asynchronously mid-cycle forces CHOR_ to all ones immediately.

Source files
------------

// File: rtl/chan_pkg.sv
// Shared definitions for the channel output bank: write modes, address width, hit decode.
package chan_pkg;

  localparam int unsigned CHAN_W = 9;

  typedef enum logic [1:0] {
    WM_LOAD = 2'b00,
    WM_OR   = 2'b01,
    WM_AND  = 2'b10,
    WM_RSVD = 2'b11
  } wmode_e;

  // True when chan addresses one of the n channels starting at base.
  function automatic logic chan_hit(input logic [CHAN_W-1:0] chan,
                                    input int unsigned base,
                                    input int unsigned n);
    int unsigned c;
    c = 32'(chan);
    return (c >= base) && ((c - base) < n);
  endfunction

endpackage

// File: rtl/jet_stretch.sv
// One jet-command bit: guarantees a minimum on-time after each rising edge of r.
module jet_stretch #(
  parameter int unsigned MINON = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic r,
  output logic hold_c
);

  localparam int unsigned TW = $clog2(MINON + 1);

  logic          r_q;
  logic [TW-1:0] t_q;

  // Rising edge of r reloads the hold timer; otherwise it counts down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
      t_q <= '0;
    end else if (clr) begin
      r_q <= 1'b0;
      t_q <= '0;
    end else begin
      r_q <= r;
      if (r && !r_q) begin
        t_q <= TW'(MINON - 1);
      end else if (t_q != '0) begin
        t_q <= t_q - TW'(1);
      end
    end
  end

  // Hold extends the output for the remainder of the minimum on-time.
  assign hold_c = (t_q != '0);

endmodule

// File: rtl/chan_out_bank.sv
// Bank of N active-low-written output channels with readback, flash gating and jet stretching.
module chan_out_bank
  import chan_pkg::*;
#(
  parameter int unsigned     N          = 4,
  parameter int unsigned     W          = 14,
  parameter int unsigned     BASE_CH    = 5,
  parameter logic [N*W-1:0]  FLASH_MASK = '0,
  parameter logic [N*W-1:0]  JET_MASK   = '0,
  parameter int unsigned     MINON      = 8
) (
  input  logic              CLOCK,
  input  logic              rst_,
  input  logic              GOJAM,
  input  logic [CHAN_W-1:0] CHAN,
  input  logic              WCH_,
  input  logic [1:0]        WMODE,
  input  logic              CCH_,
  input  logic              RCH_,
  input  logic [W-1:0]      CHWL_,
  input  logic              FLASH,
  output logic [W-1:0]      CHOR_,
  output logic [N*W-1:0]    CHAN_Q
);

  logic [N*W-1:0]    r_q;
  logic [N*W-1:0]    r_d;
  logic [N*W-1:0]    hold_c;
  logic              hit_c;
  logic [CHAN_W-1:0] k_c;
  logic [W-1:0]      d_c;
  logic [W-1:0]      base_c;
  logic [W-1:0]      rd_c;

  assign hit_c = chan_hit(CHAN, BASE_CH, N);
  assign k_c   = CHAN - CHAN_W'(BASE_CH);
  assign d_c   = ~CHWL_;

  // Next register values: GOJAM clears all, else clear-then-write on the addressed channel.
  always_comb begin
    r_d    = r_q;
    base_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (GOJAM) begin
        r_d[i*W +: W] = '0;
      end else if (hit_c && (k_c == CHAN_W'(i))) begin
        base_c = CCH_ ? r_q[i*W +: W] : '0;
        if (!WCH_) begin
          case (wmode_e'(WMODE))
            WM_OR:   r_d[i*W +: W] = base_c | d_c;
            WM_AND:  r_d[i*W +: W] = base_c & d_c;
            default: r_d[i*W +: W] = d_c;
          endcase
        end else begin
          r_d[i*W +: W] = base_c;
        end
      end
    end
  end

  // Readback of the addressed channel's pre-update value, idle bus is all ones.
  always_comb begin
    rd_c = '1;
    for (int i = 0; i < int'(N); i++) begin
      if (!RCH_ && hit_c && (k_c == CHAN_W'(i))) begin
        rd_c = ~r_q[i*W +: W];
      end
    end
  end

  // Minimum on-time stretchers exist only on bits flagged as jet commands.
  for (genvar b = 0; b < int'(N*W); b++) begin : g_bit
    if (JET_MASK[b]) begin : g_jet
      jet_stretch #(.MINON(MINON)) u_jet (
        .clk    (CLOCK),
        .rst_n  (rst_),
        .clr    (GOJAM),
        .r      (r_q[b]),
        .hold_c (hold_c[b])
      );
    end else begin : g_plain
      assign hold_c[b] = 1'b0;
    end
  end

  // Channel registers, read bus and gated effective outputs.
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      r_q    <= '0;
      CHOR_  <= '1;
      CHAN_Q <= '0;
    end else begin
      r_q    <= r_d;
      CHOR_  <= rd_c;
      CHAN_Q <= (r_q | hold_c) & ({(N*W){FLASH}} | ~FLASH_MASK);
    end
  end

endmodule

// File: tb/tb_chan_out_bank.sv
// Scoreboard bench for chan_out_bank: stimulus schedules expectations, a monitor checks them.
module tb_chan_out_bank;
  import chan_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 14;
  localparam int unsigned QW = N * W;

  logic          CLOCK = 1'b0;
  logic          rst_;
  logic          GOJAM;
  logic [8:0]    CHAN;
  logic          WCH_;
  logic [1:0]    WMODE;
  logic          CCH_;
  logic          RCH_;
  logic [W-1:0]  CHWL_;
  logic          FLASH;
  logic [W-1:0]  CHOR_;
  logic [QW-1:0] CHAN_Q;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int            at;
    logic [QW-1:0] val;
    string         nm;
  } qexp_t;

  qexp_t        q_exp[$];
  logic [W-1:0] rd_exp[$];

  chan_out_bank #(
    .N(4), .W(14), .BASE_CH(5),
    .FLASH_MASK(56'h8), .JET_MASK(56'h1), .MINON(8)
  ) dut (
    .CLOCK (CLOCK),
    .rst_  (rst_),
    .GOJAM (GOJAM),
    .CHAN  (CHAN),
    .WCH_  (WCH_),
    .WMODE (WMODE),
    .CCH_  (CCH_),
    .RCH_  (RCH_),
    .CHWL_ (CHWL_),
    .FLASH (FLASH),
    .CHOR_ (CHOR_),
    .CHAN_Q(CHAN_Q)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Insert an expected CHAN_Q value for a given edge count, kept in time order.
  task automatic sched(input int at, input logic [QW-1:0] v, input string nm);
    int p;
    p = q_exp.size();
    while (p > 0 && q_exp[p-1].at > at) p--;
    q_exp.insert(p, '{at: at, val: v, nm: nm});
  endtask

  // Monitor: checks due CHAN_Q expectations and every non-idle CHOR_ value.
  always @(negedge CLOCK) begin
    qexp_t e;
    while (q_exp.size() > 0 && q_exp[0].at <= cyc) begin
      e = q_exp.pop_front();
      chk(e.nm, 64'(CHAN_Q), 64'(e.val));
    end
    if (rst_ === 1'b1 && CHOR_ !== '1) begin
      if (rd_exp.size() == 0) chk("chor_unexpected", 64'(CHOR_), 64'({W{1'b1}}));
      else chk("chor_read", 64'(CHOR_), 64'(rd_exp.pop_front()));
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_in();
    WCH_ = 1'b1; CCH_ = 1'b1; RCH_ = 1'b1;
    CHWL_ = '1; CHAN = '0; WMODE = 2'b00;
  endtask

  task automatic idle(input int n);
    idle_in();
    repeat (n) tick();
  endtask

  task automatic wr(input logic [8:0] ch, input logic [1:0] m, input logic [W-1:0] d, input logic clr);
    CHAN = ch; WMODE = m; CHWL_ = ~d; WCH_ = 1'b0; CCH_ = ~clr; RCH_ = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [8:0] ch, input logic has, input logic [W-1:0] r);
    if (has) rd_exp.push_back(~r);
    CHAN = ch; RCH_ = 1'b0; WCH_ = 1'b1; CCH_ = 1'b1;
    tick();
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a;
    int e;
    localparam logic [QW-1:0] B1 = 56'h554000;

    rst_ = 1'b0; GOJAM = 1'b0; FLASH = 1'b1;
    idle_in();
    repeat (2) @(posedge CLOCK);
    #1;
    chk("reset_chan_q", 64'(CHAN_Q), 64'h0);
    chk("reset_chor", 64'(CHOR_), 64'h3FFF);
    rst_ = 1'b1;
    tick();

    // Load on channel 6
    wr(9'd6, WM_LOAD, 14'h0155, 1'b0);
    sched(cyc + 1, B1, "load_ch6");
    idle(3);

    // Load / OR / AND back-to-back on channel 5 (bit 0 is a jet bit)
    wr(9'd5, WM_LOAD, 14'h00F0, 1'b0);
    a = cyc;
    sched(a + 1, B1 | 56'hF0, "load_ch5");
    wr(9'd5, WM_OR, 14'h000F, 1'b0);
    sched(a + 2, B1 | 56'hFF, "or_ch5");
    wr(9'd5, WM_AND, 14'h003C, 1'b0);
    sched(a + 3,  B1 | 56'h3D, "and_ch5_stretched");
    sched(a + 9,  B1 | 56'h3D, "and_ch5_stretch_end");
    sched(a + 10, B1 | 56'h3C, "and_ch5_settled");
    idle(12);
    rd(9'd5, 1'b1, 14'h003C);
    rd(9'd6, 1'b1, 14'h0155);
    rd(9'd9, 1'b0, '0);
    rd(9'd4, 1'b0, '0);
    idle(1);

    // Clear and write together on channel 7, then out-of-range writes
    wr(9'd7, WM_LOAD, 14'h2001, 1'b0); idle(1);
    wr(9'd7, WM_LOAD, 14'h1234, 1'b1); idle(1);
    rd(9'd7, 1'b1, 14'h1234);
    wr(9'd7, WM_OR, 14'h0F00, 1'b1); idle(1);
    rd(9'd7, 1'b1, 14'h0F00);
    wr(9'd7, WM_AND, 14'h1234, 1'b1);
    sched(cyc + 1, B1 | 56'h3C, "clr_and_ch7");
    idle(2);
    wr(9'd9,   WM_LOAD, 14'h3FFF, 1'b1);
    wr(9'd4,   WM_LOAD, 14'h3FFF, 1'b1);
    wr(9'h105, WM_LOAD, 14'h3FFF, 1'b1);
    sched(cyc + 1, B1 | 56'h3C, "miss_writes");
    idle(3);

    // Single-cycle jet bit
    wr(9'd5, WM_OR, 14'h0001, 1'b0);
    e = cyc;
    sched(e,     B1 | 56'h3C, "jet_pre");
    sched(e + 1, B1 | 56'h3D, "jet_first");
    sched(e + 8, B1 | 56'h3D, "jet_last");
    sched(e + 9, B1 | 56'h3C, "jet_off");
    wr(9'd5, WM_AND, 14'h3FFE, 1'b0);
    idle(12);

    // Jet bit re-set 5 cycles later extends the hold
    wr(9'd5, WM_OR, 14'h0001, 1'b0);
    e = cyc;
    sched(e + 1,  B1 | 56'h3D, "jet_re_first");
    sched(e + 9,  B1 | 56'h3D, "jet_extend");
    sched(e + 13, B1 | 56'h3D, "jet_extend_last");
    sched(e + 14, B1 | 56'h3C, "jet_extend_off");
    wr(9'd5, WM_AND, 14'h3FFE, 1'b0);
    idle(3);
    wr(9'd5, WM_OR, 14'h0001, 1'b0);
    wr(9'd5, WM_AND, 14'h3FFE, 1'b0);
    idle(12);

    // Jet bit held longer than the minimum on-time
    wr(9'd5, WM_OR, 14'h0001, 1'b0);
    e = cyc;
    sched(e + 12, B1 | 56'h3D, "jet_long_on");
    sched(e + 13, B1 | 56'h3C, "jet_long_off");
    idle(11);
    wr(9'd5, WM_AND, 14'h3FFE, 1'b0);
    idle(3);

    // Flash gating of bit 3
    e = cyc;
    sched(e,     B1 | 56'h3C, "flash_pre");
    sched(e + 1, B1 | 56'h34, "flash_dark");
    sched(e + 2, B1 | 56'h34, "flash_dark2");
    sched(e + 3, B1 | 56'h3C, "flash_lit");
    FLASH = 1'b0;
    tick(); tick();
    FLASH = 1'b1;
    tick();
    idle(2);

    // GOJAM during a stretch
    wr(9'd5, WM_OR, 14'h0001, 1'b0);
    e = cyc;
    wr(9'd5, WM_AND, 14'h3FFE, 1'b0);
    idle_in();
    tick();
    sched(e + 3, B1 | 56'h3D, "gojam_pre");
    sched(e + 4, '0, "gojam_clear");
    sched(e + 7, '0, "gojam_no_hold");
    GOJAM = 1'b1;
    tick();
    GOJAM = 1'b0;
    idle(6);

    // Asynchronous reset mid-cycle, mid-stretch, with a read in flight
    wr(9'd6, WM_LOAD, 14'h0155, 1'b0);
    idle(2);
    wr(9'd5, WM_OR, 14'h0001, 1'b0);
    wr(9'd5, WM_AND, 14'h3FFE, 1'b0);
    idle_in();
    rd_exp.push_back(~14'h0155);
    CHAN = 9'd6; RCH_ = 1'b0;
    tick();
    #6;
    rst_ = 1'b0;
    #1;
    chk("async_rst_chor", 64'(CHOR_), 64'h3FFF);
    chk("async_rst_chan_q", 64'(CHAN_Q), 64'h0);
    idle_in();
    tick();
    rst_ = 1'b1;
    e = cyc;
    sched(e + 1, '0, "post_rst_no_hold");
    sched(e + 3, '0, "post_rst_still_clear");
    idle(5);

    chk("exp_queue_drained", 64'(q_exp.size()), 64'h0);
    chk("rd_queue_drained", 64'(rd_exp.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
